// File: rtl/flash_addr_fsm.sv
// Avalon-MM read master that walks the flash audio region one 32-bit word per sample pair.
// Step requests arrive from the sampling_clk domain and are synchronised and edge-detected on clk.
module flash_addr_fsm #(
    parameter logic [22:0] FIRST_ADDR = 23'h000000,
    parameter logic [22:0] LAST_ADDR  = 23'h07FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_flash_en,
    input  logic        count_up,
    input  logic        restart,
    input  logic        get_new_address,
    input  logic        flash_mem_waitrequest,
    input  logic        flash_mem_readdatavalid,
    input  logic [31:0] flash_mem_readdata,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    output logic [31:0] flash_data,
    output logic        data_valid_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        WAIT_TRIG,
        STEP,
        RESTART
    } state_t;

    state_t      state;
    logic        gna_meta;
    logic        gna_sync;
    logic        gna_prev;
    logic        step_req;
    logic        pending_step;
    logic        pending_restart;
    logic [22:0] next_addr;

    assign step_req             = gna_sync & ~gna_prev;
    assign flash_mem_byteenable = 4'hF;

    // Wrap at both ends of the region so the address never leaves [FIRST_ADDR, LAST_ADDR].
    always_comb begin
        next_addr = flash_mem_address;
        if (count_up) begin
            next_addr = (flash_mem_address >= LAST_ADDR) ? FIRST_ADDR : flash_mem_address + 23'd1;
        end else begin
            next_addr = (flash_mem_address <= FIRST_ADDR) ? LAST_ADDR : flash_mem_address - 23'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            flash_mem_address <= FIRST_ADDR;
            flash_mem_read    <= 1'b0;
            flash_data        <= '0;
            data_valid_pulse  <= 1'b0;
            gna_meta          <= 1'b0;
            gna_sync          <= 1'b0;
            gna_prev          <= 1'b0;
            pending_step      <= 1'b0;
            pending_restart   <= 1'b0;
        end else begin
            gna_meta         <= get_new_address;
            gna_sync         <= gna_meta;
            gna_prev         <= gna_sync;
            data_valid_pulse <= 1'b0;

            // One-deep request capture while a fetch is in flight; restart overrides a step.
            if (state inside {READ, WAIT_DATA, STEP, RESTART}) begin
                if (restart) begin
                    pending_restart <= 1'b1;
                    pending_step    <= 1'b0;
                end else if (step_req && !pending_restart) begin
                    pending_step <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    pending_step    <= 1'b0;
                    pending_restart <= 1'b0;
                    if (read_flash_en) begin
                        flash_mem_read <= 1'b1;
                        state          <= READ;
                    end
                end
                READ: begin
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        state          <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        flash_data       <= flash_mem_readdata;
                        data_valid_pulse <= 1'b1;
                        state            <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (!read_flash_en) begin
                        pending_step    <= 1'b0;
                        pending_restart <= 1'b0;
                        state           <= IDLE;
                    end else if (restart || pending_restart) begin
                        pending_step    <= 1'b0;
                        pending_restart <= 1'b0;
                        state           <= RESTART;
                    end else if (step_req || pending_step) begin
                        pending_step <= 1'b0;
                        state        <= STEP;
                    end
                end
                STEP: begin
                    flash_mem_address <= next_addr;
                    flash_mem_read    <= 1'b1;
                    state             <= READ;
                end
                RESTART: begin
                    flash_mem_address <= count_up ? FIRST_ADDR : LAST_ADDR;
                    flash_mem_read    <= 1'b1;
                    state             <= READ;
                end
                default: begin
                    flash_mem_read <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_addr_fsm.sv
// Directed bench for flash_addr_fsm: a transaction-level address/data model plus a per-cycle
// Avalon slave and checker running on the falling clock edge.
module tb_flash_addr_fsm;

    localparam logic [22:0] FIRST = 23'h000000;
    localparam logic [22:0] LAST  = 23'h07FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_flash_en = 1'b0;
    logic        count_up = 1'b1;
    logic        restart = 1'b0;
    logic        get_new_address = 1'b0;
    logic        flash_mem_waitrequest = 1'b0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] flash_data;
    logic        data_valid_pulse;

    flash_addr_fsm #(.FIRST_ADDR(FIRST), .LAST_ADDR(LAST)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .read_flash_en          (read_flash_en),
        .count_up               (count_up),
        .restart                (restart),
        .get_new_address        (get_new_address),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_data             (flash_data),
        .data_valid_pulse       (data_valid_pulse)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    logic [22:0] exp_q[$];
    logic [22:0] model_addr = FIRST;
    logic [31:0] model_data = '0;
    logic [31:0] pend_data = '0;
    logic [22:0] prev_addr = '0;
    logic        prev_stall = 1'b0;
    logic        pulse_due = 1'b0;
    logic        outstanding = 1'b0;
    int          lat_cnt = 0;
    int          lat_val = 3;
    int          wr_hold = 0;
    int          stall_cnt = 0;
    int          reads_accepted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] step_model(input logic [22:0] a, input logic up);
        if (up) return (a == LAST) ? FIRST : a + 23'd1;
        return (a == FIRST) ? LAST : a - 23'd1;
    endfunction

    // Avalon slave behaviour and per-cycle output checks.
    always @(negedge clk) begin
        check("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
        check("valid_pulse", {31'd0, data_valid_pulse}, {31'd0, pulse_due});
        check("flash_data", flash_data, model_data);
        if (prev_stall) begin
            check("stall_read", {31'd0, flash_mem_read}, 32'd1);
            check("stall_addr", {9'd0, flash_mem_address}, {9'd0, prev_addr});
        end
        pulse_due = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        if (reset) begin
            lat_cnt = 0;
            outstanding = 1'b0;
            model_data = '0;
            flash_mem_waitrequest = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata = pend_data;
                    if (outstanding) begin
                        pulse_due = 1'b1;
                        model_data = pend_data;
                        outstanding = 1'b0;
                    end
                end
            end
            flash_mem_waitrequest = flash_mem_read && (wr_hold > 0);
            if (flash_mem_waitrequest) begin
                wr_hold--;
                stall_cnt++;
            end
            prev_stall = flash_mem_waitrequest;
            prev_addr = flash_mem_address;
            if (flash_mem_read && !flash_mem_waitrequest) begin
                reads_accepted++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_read: got read at %h, expected none", flash_mem_address);
                end else begin
                    check("read_addr", {9'd0, flash_mem_address}, {9'd0, exp_q.pop_front()});
                end
                pend_data = 32'hA5A5_1234 + 32'(reads_accepted - 1) * 32'h0101_0101;
                lat_cnt = lat_val;
                outstanding = 1'b1;
            end
        end
    end

    task automatic wait_pulse(input string name);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (data_valid_pulse) return;
        end
        vectors++;
        errors++;
        $display("FAIL %s_timeout: got no data_valid_pulse, expected one within 80 cycles", name);
    endtask

    task automatic wait_accept(input int target);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (reads_accepted >= target) return;
        end
        vectors++;
        errors++;
        $display("FAIL accept_timeout: got %0d reads, expected %0d", reads_accepted, target);
    endtask

    task automatic do_step(input logic up);
        count_up = up;
        model_addr = step_model(model_addr, up);
        exp_q.push_back(model_addr);
        get_new_address = 1'b1;
        wait_pulse("step");
        get_new_address = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_restart(input logic up);
        count_up = up;
        model_addr = up ? FIRST : LAST;
        exp_q.push_back(model_addr);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_pulse("restart");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_addr", {9'd0, flash_mem_address}, 32'd0);
        check("rst_read", {31'd0, flash_mem_read}, 32'd0);
        check("rst_data", flash_data, 32'd0);
        check("rst_pulse", {31'd0, data_valid_pulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Initial fetch at the current address, no step.
        exp_q.push_back(model_addr);
        read_flash_en = 1'b1;
        wait_pulse("first");
        check("first_data", flash_data, 32'hA5A5_1234);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) do_step(1'b1);
        check("addr_after_4", {9'd0, flash_mem_address}, 32'd4);
        check("model_after_4", {9'd0, model_addr}, 32'd4);

        // Wrap in both directions.
        do_restart(1'b0);
        check("restart_down", {9'd0, flash_mem_address}, 32'h07FFFF);
        do_step(1'b1);
        check("wrap_up", {9'd0, flash_mem_address}, 32'h000000);
        do_step(1'b0);
        check("wrap_down", {9'd0, flash_mem_address}, 32'h07FFFF);

        // Five-cycle waitrequest stall on one read.
        base = stall_cnt;
        wr_hold = 5;
        do_step(1'b1);
        check("stall_cycles", 32'(stall_cnt - base), 32'd5);

        // Step edge and down-restart during WAIT_DATA: restart wins, step dropped.
        lat_val = 8;
        base = reads_accepted;
        count_up = 1'b1;
        model_addr = FIRST;
        exp_q.push_back(model_addr);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_accept(base + 1);
        @(negedge clk);
        count_up = 1'b0;
        model_addr = LAST;
        exp_q.push_back(model_addr);
        restart = 1'b1;
        get_new_address = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_pulse("busy_first");
        wait_pulse("busy_second");
        check("busy_restart_addr", {9'd0, flash_mem_address}, 32'h07FFFF);
        get_new_address = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_read_count", 32'(reads_accepted - base), 32'd2);
        check("busy_queue_empty", 32'(exp_q.size()), 32'd0);

        // Enable dropped after accept: data still lands, then idle.
        lat_val = 3;
        base = reads_accepted;
        count_up = 1'b1;
        model_addr = step_model(model_addr, 1'b1);
        exp_q.push_back(model_addr);
        get_new_address = 1'b1;
        wait_accept(base + 1);
        read_flash_en = 1'b0;
        get_new_address = 1'b0;
        wait_pulse("en_drop");
        check("en_drop_data", flash_data, 32'hA5A5_1234 + 32'(base) * 32'h0101_0101);
        repeat (6) @(negedge clk);
        get_new_address = 1'b1;
        repeat (8) @(negedge clk);
        get_new_address = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_read", {31'd0, flash_mem_read}, 32'd0);
        check("idle_addr", {9'd0, flash_mem_address}, 32'd0);
        check("idle_read_count", 32'(reads_accepted - base), 32'd1);
        check("idle_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before 2 ms");
        $fatal(1);
    end

endmodule
